// File: rtl/led_pkg.sv
// Shared types and helpers for the LED chain serialiser.
package led_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StShiftLo = 2'd1,
    StShiftHi = 2'd2,
    StLatch   = 2'd3
  } state_e;

  localparam int unsigned LED_PER_BOARD = 8;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/led_tick_gen.sv
// DIV-cycle phase divider: strobes phase_end on the last cycle of each phase.
module led_tick_gen
  import led_pkg::*;
#(
  parameter int unsigned DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic phase_end
);

  localparam int unsigned W = cnt_width(DIV);
  localparam logic [W-1:0] Last = W'(DIV - 1);

  logic [W-1:0] cnt_q;

  assign phase_end = run && (cnt_q == Last);

  // Clearing on phase_end restarts the count for every new phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (!run || phase_end) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + W'(1);
    end
  end

endmodule

// File: rtl/led_chain_tx.sv
// Serialises an NUM*8-bit LED vector onto a 74HC595-style chain (sclk/sdata/latch).
// Optional LED_CHAIN_AUTO_REFRESH_EN: resend automatically whenever led_all changes.
module led_chain_tx
  import led_pkg::*;
#(
  parameter int unsigned NUM = 4,
  parameter int unsigned DIV = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM*LED_PER_BOARD-1:0] led_all,
  input  logic                         start,
  output logic                         sclk,
  output logic                         sdata,
  output logic                         latch,
  output logic                         busy,
  output logic                         done
);

  localparam int unsigned W  = NUM * LED_PER_BOARD;
  localparam int unsigned BW = cnt_width(W);
  localparam logic [BW-1:0] LastBit = BW'(W - 1);

  state_e        state_q;
  logic [W-2:0]  rest_q;   // bits still to send after the one on sdata
  logic [BW-1:0] bit_cnt_q;
  logic          phase_end;
  logic          go;

`ifdef LED_CHAIN_AUTO_REFRESH_EN
  logic [W-1:0] last_q;
  logic         first_q;
  assign go = !done && (start || first_q || (led_all != last_q));
`else
  assign go = !done && start;
`endif

  led_tick_gen #(
    .DIV(DIV)
  ) u_tick (
    .clk      (clk),
    .rst      (rst),
    .run      (state_q != StIdle),
    .phase_end(phase_end)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      sclk      <= 1'b0;
      sdata     <= 1'b0;
      latch     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      rest_q    <= '0;
      bit_cnt_q <= '0;
`ifdef LED_CHAIN_AUTO_REFRESH_EN
      last_q    <= '0;
      first_q   <= 1'b1;
`endif
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
`ifdef LED_CHAIN_AUTO_REFRESH_EN
          first_q <= 1'b0;
`endif
          if (go) begin
            rest_q    <= led_all[W-2:0];
            bit_cnt_q <= '0;
            sdata     <= led_all[W-1];
            busy      <= 1'b1;
            state_q   <= StShiftLo;
`ifdef LED_CHAIN_AUTO_REFRESH_EN
            last_q    <= led_all;
`endif
          end
        end
        StShiftLo: begin
          if (phase_end) begin
            sclk    <= 1'b1;
            state_q <= StShiftHi;
          end
        end
        StShiftHi: begin
          if (phase_end) begin
            sclk <= 1'b0;
            if (bit_cnt_q == LastBit) begin
              latch   <= 1'b1;
              state_q <= StLatch;
            end else begin
              bit_cnt_q <= bit_cnt_q + BW'(1);
              sdata     <= rest_q[W-2];
              rest_q    <= {rest_q[W-3:0], 1'b0};
              state_q   <= StShiftLo;
            end
          end
        end
        StLatch: begin
          if (phase_end) begin
            latch   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
            sdata   <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_led_chain_tx.sv
// Directed bench for led_chain_tx (NUM=4/DIV=4 and NUM=1/DIV=1 instances).
module tb_led_chain_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] led_all = 32'd0;
  logic        start = 1'b0;
  logic        sclk, sdata, latch, busy, done;

  logic [7:0]  s_led = 8'd0;
  logic        s_start = 1'b0;
  logic        s_sclk, s_sdata, s_latch, s_busy, s_done;

  int          checks = 0;
  int          failures = 0;

  int          busy_cnt, rises, latch_cnt, done_cnt;
  logic [31:0] bits;
  logic        prev_sclk;

  led_chain_tx #(.NUM(4), .DIV(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .led_all(led_all),
    .start  (start),
    .sclk   (sclk),
    .sdata  (sdata),
    .latch  (latch),
    .busy   (busy),
    .done   (done)
  );

  led_chain_tx #(.NUM(1), .DIV(1)) dut_s (
    .clk    (clk),
    .rst    (rst),
    .led_all(s_led),
    .start  (s_start),
    .sclk   (s_sclk),
    .sdata  (s_sdata),
    .latch  (s_latch),
    .busy   (s_busy),
    .done   (s_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Call at a negedge; samples the big instance once per cycle and applies stimulus.
  task automatic watch(input int max_cyc, input int chg_at, input logic [31:0] chg_val,
                       input int sa, input int sb, input int rst_at);
    int tail;
    busy_cnt  = 0;
    rises     = 0;
    latch_cnt = 0;
    done_cnt  = 0;
    bits      = 32'd0;
    prev_sclk = 1'b0;
    tail      = -1;
    for (int c = 0; c < max_cyc; c++) begin
      if (busy)  busy_cnt++;
      if (latch) latch_cnt++;
      if (done)  done_cnt++;
      if (sclk && !prev_sclk) begin
        rises++;
        bits = {bits[30:0], sdata};
      end
      prev_sclk = sclk;
      if (done && tail < 0) tail = 5;
      start = (c == sa) || (c == sb);
      if (c == chg_at) led_all = chg_val;
      if (c == rst_at) begin
        rst = 1'b1;
        #1;
        check("reset_outputs_zero", {27'd0, sclk, sdata, latch, busy, done}, 32'd0);
      end
      if (c == rst_at + 3) rst = 1'b0;
      if (tail == 0) break;
      if (tail > 0) tail--;
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic kick(input logic [31:0] pat);
    led_all = pat;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
  endtask

  initial begin
`ifdef LED_CHAIN_AUTO_REFRESH_EN
    led_all = 32'h1234_5678;
`endif
    repeat (3) @(negedge clk);
    check("reset_state", {22'd0, sclk, sdata, latch, busy, done,
                          s_sclk, s_sdata, s_latch, s_busy, s_done}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

`ifdef LED_CHAIN_AUTO_REFRESH_EN
    watch(400, -1, 32'd0, -1, -1, -1);
    check("auto_first_rises", rises, 32);
    check("auto_first_bits", bits, 32'h1234_5678);
    check("auto_first_done", done_cnt, 1);
    watch(300, -1, 32'd0, -1, -1, -1);
    check("auto_steady_busy", busy_cnt, 0);
    led_all = 32'h0000_0002;
    watch(400, -1, 32'd0, -1, -1, -1);
    check("auto_change_rises", rises, 32);
    check("auto_change_bits", bits, 32'h0000_0002);
    check("auto_change_done", done_cnt, 1);
    watch(300, -1, 32'd0, -1, -1, -1);
    check("auto_after_busy", busy_cnt, 0);
`else
    // Basic frame.
    kick(32'h0101_0101);
    watch(400, -1, 32'd0, -1, -1, -1);
    check("f1_busy_cycles", busy_cnt, 260);
    check("f1_sclk_rises", rises, 32);
    check("f1_bits", bits, 32'h0101_0101);
    check("f1_latch_cycles", latch_cnt, 4);
    check("f1_done_pulses", done_cnt, 1);

    // Input change mid-frame must not corrupt the snapshot.
    kick(32'hA5C3_0F81);
    watch(400, 20, 32'hFFFF_FFFF, -1, -1, -1);
    check("f2_sclk_rises", rises, 32);
    check("f2_bits", bits, 32'hA5C3_0F81);

    // Start pulses while busy are ignored.
    kick(32'h3C3C_55AA);
    watch(400, -1, 32'd0, 10, 150, -1);
    check("f3_sclk_rises", rises, 32);
    check("f3_done_pulses", done_cnt, 1);
    check("f3_busy_cycles", busy_cnt, 260);
    check("f3_bits", bits, 32'h3C3C_55AA);

    // Reset mid-shift aborts without a latch pulse.
    kick(32'hDEAD_BEEF);
    watch(300, -1, 32'd0, -1, -1, 100);
    check("rst_no_latch", latch_cnt, 0);
    check("rst_no_done", done_cnt, 0);
    check("rst_idle_after", {31'd0, busy}, 32'd0);
    kick(32'hC0FF_EE11);
    watch(400, -1, 32'd0, -1, -1, -1);
    check("post_rst_rises", rises, 32);
    check("post_rst_bits", bits, 32'hC0FF_EE11);
    check("post_rst_done", done_cnt, 1);

    // NUM=1, DIV=1 instance.
    begin
      int          sb_cnt, sl_cnt, sd_cnt, s_rises, s_hi;
      logic [7:0]  s_bits;
      logic        s_prev;
      sb_cnt = 0; sl_cnt = 0; sd_cnt = 0; s_rises = 0; s_hi = 0;
      s_bits = 8'd0; s_prev = 1'b0;
      s_led   = 8'h80;
      s_start = 1'b1;
      @(negedge clk);
      s_start = 1'b0;
      for (int c = 0; c < 40; c++) begin
        if (s_busy) sb_cnt++;
        if (s_latch) sl_cnt++;
        if (s_done) sd_cnt++;
        if (s_busy && s_sdata) s_hi++;
        if (s_sclk && !s_prev) begin
          s_rises++;
          s_bits = {s_bits[6:0], s_sdata};
        end
        s_prev = s_sclk;
        @(negedge clk);
      end
      check("s_busy_cycles", sb_cnt, 17);
      check("s_sclk_rises", s_rises, 8);
      check("s_bits", {24'd0, s_bits}, 32'h80);
      check("s_sdata_hi_cycles", s_hi, 2);
      check("s_latch_cycles", sl_cnt, 1);
      check("s_done_pulses", sd_cnt, 1);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
